// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY framing constants, rate encoding and small helpers used by
// the transmit framer.
package pcie_phy_pkg;

  localparam logic [7:0]  SDP            = 8'h5C;
  localparam logic [7:0]  STP            = 8'hFB;
  localparam logic [7:0]  ENDP           = 8'hFD;
  localparam logic [15:0] GEN3_SDP_TOKEN = 16'hACF0;

  localparam int TUSER_DLLP_BIT = 0;
  localparam int TUSER_TLP_BIT  = 1;

  typedef enum logic [1:0] {
    RATE_GEN1 = 2'd0,
    RATE_GEN2 = 2'd1,
    RATE_GEN3 = 2'd2
  } rate_speed_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } framer_state_e;

  // Number of valid bytes in a contiguous-from-lane-0 keep mask.
  function automatic logic [2:0] keep_count(input logic [3:0] keep);
    casez (keep)
      4'b1???: keep_count = 3'd4;
      4'b01??: keep_count = 3'd3;
      4'b001?: keep_count = 3'd2;
      default: keep_count = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dllp_tx_framer.sv
// PCIe TX framer: prepends SDP/STP (Gen1/2) or the SDP token (Gen3), appends
// ENDP at Gen1/2, and packs byte-shifted 32-bit words into the PHY TX FIFO.
module dllp_tx_framer
  import pcie_phy_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  phy_link_up_i,
  input  rate_speed_e           curr_data_rate_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  input  logic                  phy_fifo_full_i,
  output logic                  phy_fifo_wr_en_o,
  output logic [31:0]           data_o,
  output logic                  data_valid_o,
  output logic [3:0]            data_k_o,
  output logic [1:0]            sync_header_o,
  output logic                  frame_err_o
);

  // Handshake: a beat transfers on a rising clk_i edge where s_axis_tvalid and
  // s_axis_tready are both high; a word leaves on an edge where
  // phy_fifo_wr_en_o is high. Neither side may depend on the other's
  // acceptance to raise its valid.

  framer_state_e state, state_nxt;

  logic        gen3_q;
  logic [15:0] carry_q;
  logic [31:0] rem_q;
  logic [3:0]  rem_k_q;

  logic        ld, accept, link_drop, bad_sop, is_tlp_in;
  logic        frame_beat, emit, err_evt, gen3_cur, trailer, overflow;
  logic [3:0]  s_len, n_len, total;
  logic [15:0] lead;
  logic [1:0]  lead_k;
  logic [63:0] buf_d;
  logic [7:0]  buf_k;
  logic [31:0] emit_word;
  logic [3:0]  emit_k;
  logic        unused_tuser;

  assign unused_tuser = ^s_axis_tuser;

  assign ld               = !data_valid_o || !phy_fifo_full_i;
  assign phy_fifo_wr_en_o = data_valid_o && !phy_fifo_full_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bad_sop)           state_nxt = s_axis_tlast ? ST_IDLE : ST_DROP;
          else if (s_axis_tlast) state_nxt = overflow ? ST_FLUSH : ST_IDLE;
          else                   state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (link_drop)                    state_nxt = (accept && s_axis_tlast) ? ST_IDLE : ST_DROP;
        else if (accept && s_axis_tlast)  state_nxt = overflow ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: if (ld) state_nxt = ST_IDLE;
      ST_DROP:  if (s_axis_tvalid && s_axis_tlast) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    is_tlp_in = s_axis_tuser[TUSER_TLP_BIT] && !s_axis_tuser[TUSER_DLLP_BIT];
    bad_sop   = !phy_link_up_i
             || !(s_axis_tuser[TUSER_DLLP_BIT] || s_axis_tuser[TUSER_TLP_BIT])
             || (is_tlp_in && curr_data_rate_i == RATE_GEN3);
    link_drop = (state == ST_DATA) && !phy_link_up_i;

    s_axis_tready = !rst_i && ((state == ST_DROP) || link_drop
                    || (ld && (state == ST_IDLE || state == ST_DATA)));
    accept     = s_axis_tvalid && s_axis_tready;
    frame_beat = accept && (((state == ST_IDLE) && !bad_sop)
                            || ((state == ST_DATA) && phy_link_up_i));
    err_evt    = (accept && (state == ST_IDLE) && bad_sop) || link_drop;

    // Rate is sampled at SOP and held for the rest of the packet.
    gen3_cur = (state == ST_IDLE) ? (curr_data_rate_i == RATE_GEN3) : gen3_q;
    s_len    = gen3_cur ? 4'd2 : 4'd1;
    n_len    = s_axis_tlast ? {1'b0, keep_count(s_axis_tkeep)} : 4'd4;
    trailer  = s_axis_tlast && !gen3_cur;
    total    = s_len + n_len + {3'b000, trailer};
    overflow = s_axis_tlast && (total > 4'd4);

    if (state == ST_IDLE) begin
      lead   = gen3_cur ? GEN3_SDP_TOKEN : {8'h00, is_tlp_in ? STP : SDP};
      lead_k = gen3_cur ? 2'b00 : 2'b01;
    end else begin
      lead   = carry_q;
      lead_k = 2'b00;
    end

    // Eight-lane staging vector: lead bytes, then beat bytes, then ENDP.
    buf_d = '0;
    buf_k = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(s_len)) begin
        buf_d[8*i +: 8] = (i == 0) ? lead[7:0] : lead[15:8];
        buf_k[i]        = (i == 0) ? lead_k[0] : lead_k[1];
      end else if (i < int'(s_len) + int'(n_len)) begin
        buf_d[8*i +: 8] = s_axis_tdata[8*(i - int'(s_len)) +: 8];
      end else if (trailer && (i == int'(s_len) + int'(n_len))) begin
        buf_d[8*i +: 8] = ENDP;
        buf_k[i]        = 1'b1;
      end
    end

    emit      = frame_beat || (state == ST_FLUSH);
    emit_word = (state == ST_FLUSH) ? rem_q   : buf_d[31:0];
    emit_k    = (state == ST_FLUSH) ? rem_k_q : buf_k[3:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gen3_q        <= 1'b0;
      carry_q       <= '0;
      rem_q         <= '0;
      rem_k_q       <= '0;
      frame_err_o   <= 1'b0;
      data_valid_o  <= 1'b0;
      data_o        <= '0;
      data_k_o      <= '0;
      sync_header_o <= '0;
    end else begin
      frame_err_o <= err_evt;
      if (frame_beat) begin
        if (state == ST_IDLE) gen3_q <= gen3_cur;
        carry_q <= gen3_cur ? buf_d[47:32] : {8'h00, buf_d[39:32]};
        if (overflow) begin
          rem_q   <= buf_d[63:32];
          rem_k_q <= buf_k[7:4];
        end
      end
      if (ld) begin
        data_valid_o <= emit;
        if (emit) begin
          data_o        <= emit_word;
          data_k_o      <= emit_k;
          sync_header_o <= gen3_cur ? 2'b01 : 2'b00;
        end
      end
    end
  end

endmodule

// File: tb/tb_dllp_tx_framer.sv
// Directed bench for dllp_tx_framer: framing at each rate, backpressure,
// dropped packets and asynchronous reset, checked against hand-derived words.
module tb_dllp_tx_framer;
  import pcie_phy_pkg::*;

  localparam int W = 38;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        phy_link_up_i;
  rate_speed_e curr_data_rate_i;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic [3:0]  s_axis_tuser;
  logic        s_axis_tready;
  logic        phy_fifo_full_i;
  logic        phy_fifo_wr_en_o;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic [3:0]  data_k_o;
  logic [1:0]  sync_header_o;
  logic        frame_err_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_word;
  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int wr_cnt   = 0;
  int base_err, base_wr;

  dllp_tx_framer dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .phy_link_up_i    (phy_link_up_i),
    .curr_data_rate_i (curr_data_rate_i),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tready    (s_axis_tready),
    .phy_fifo_full_i  (phy_fifo_full_i),
    .phy_fifo_wr_en_o (phy_fifo_wr_en_o),
    .data_o           (data_o),
    .data_valid_o     (data_valid_o),
    .data_k_o         (data_k_o),
    .sync_header_o    (sync_header_o),
    .frame_err_o      (frame_err_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] fw(input logic [1:0] sh, input logic [3:0] k, input logic [31:0] d);
    return {sh, k, d};
  endfunction

  // Scoreboard: every FIFO write must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (frame_err_o) err_cnt++;
      if (phy_fifo_wr_en_o) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_wr", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_word = exp_q.pop_front();
          check_eq("wr_word", 64'({sync_header_o, data_k_o, data_o}), 64'(exp_word));
        end
      end
    end
  end

  // Driver tasks
  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic last,
                            input logic [3:0] user);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk_i);
      acc = s_axis_tready;
      @(posedge clk_i);
      #1;
    end
    if (!acc) check_eq("accept_timeout", 64'(acc), 64'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic last,
                           input logic [3:0] user);
    drive_beat(d, k, last, user);
    wait_accept();
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk_i);
    check_eq(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic gen1_dllp(input string tag);
    curr_data_rate_i = RATE_GEN1;
    exp_q.push_back(fw(2'b00, 4'b0001, 32'h3322115C));
    exp_q.push_back(fw(2'b00, 4'b1000, 32'hFD665544));
    send_beat(32'h44332211, 4'hF, 1'b0, 4'h1);
    send_beat(32'h00006655, 4'h3, 1'b1, 4'h1);
    wait_drain(tag);
  endtask

  task automatic gen3_dllp(input string tag);
    curr_data_rate_i = RATE_GEN3;
    exp_q.push_back(fw(2'b01, 4'b0000, 32'h2211ACF0));
    exp_q.push_back(fw(2'b01, 4'b0000, 32'h66554433));
    send_beat(32'h44332211, 4'hF, 1'b0, 4'h1);
    send_beat(32'h00006655, 4'h3, 1'b1, 4'h1);
    wait_drain(tag);
  endtask

  task automatic drop_packet(input string tag, input logic [3:0] user);
    base_err = err_cnt;
    base_wr  = wr_cnt;
    for (int b = 0; b < 3; b++) begin
      drive_beat(32'hA0A0A0A0 + 32'(b), 4'hF, (b == 2), user);
      @(negedge clk_i);
      check_eq({tag, "_tready"}, 64'(s_axis_tready), 64'd1);
      @(posedge clk_i);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    check_eq({tag, "_err_pulses"}, 64'(err_cnt - base_err), 64'd1);
    check_eq({tag, "_writes"}, 64'(wr_cnt - base_wr), 64'd0);
  endtask

  initial begin
    rst_i            = 1'b1;
    phy_link_up_i    = 1'b1;
    curr_data_rate_i = RATE_GEN1;
    phy_fifo_full_i  = 1'b0;
    s_axis_tdata     = '0;
    s_axis_tkeep     = '0;
    s_axis_tvalid    = 1'b0;
    s_axis_tlast     = 1'b0;
    s_axis_tuser     = '0;

    #12;
    check_eq("rst_tready", 64'(s_axis_tready), 64'd0);
    check_eq("rst_valid", 64'(data_valid_o), 64'd0);
    check_eq("rst_wr_en", 64'(phy_fifo_wr_en_o), 64'd0);
    check_eq("rst_word", 64'({sync_header_o, data_k_o, data_o}), 64'd0);
    check_eq("rst_err", 64'(frame_err_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("idle_tready", 64'(s_axis_tready), 64'd1);
    @(posedge clk_i);
    #1;

    gen1_dllp("gen1_dllp_drain");

    // Gen1 TLP with overflow into a flush word
    exp_q.push_back(fw(2'b00, 4'b0001, 32'h332211FB));
    exp_q.push_back(fw(2'b00, 4'b0000, 32'h77665544));
    exp_q.push_back(fw(2'b00, 4'b0010, 32'h0000FD88));
    send_beat(32'h44332211, 4'hF, 1'b0, 4'h2);
    send_beat(32'h88776655, 4'hF, 1'b1, 4'h2);
    wait_drain("gen1_tlp_drain");

    gen3_dllp("gen3_dllp_drain");

    // Gen2 TLP ending in a single valid byte: no flush needed
    curr_data_rate_i = RATE_GEN2;
    exp_q.push_back(fw(2'b00, 4'b0001, 32'hCCBBAAFB));
    exp_q.push_back(fw(2'b00, 4'b0100, 32'h00FDEEDD));
    send_beat(32'hDDCCBBAA, 4'hF, 1'b0, 4'h2);
    send_beat(32'h000000EE, 4'h1, 1'b1, 4'h2);
    wait_drain("gen2_tlp_keep1_drain");

    // Single-beat Gen1 DLLP spills ENDP into a flush word
    curr_data_rate_i = RATE_GEN1;
    exp_q.push_back(fw(2'b00, 4'b0001, 32'h3322115C));
    exp_q.push_back(fw(2'b00, 4'b0010, 32'h0000FD44));
    send_beat(32'h44332211, 4'hF, 1'b1, 4'h1);
    wait_drain("gen1_single_beat_drain");

    // Backpressure mid Gen1 TLP
    exp_q.push_back(fw(2'b00, 4'b0001, 32'h332211FB));
    exp_q.push_back(fw(2'b00, 4'b0000, 32'h77665544));
    exp_q.push_back(fw(2'b00, 4'b0010, 32'h0000FD88));
    send_beat(32'h44332211, 4'hF, 1'b0, 4'h2);
    check_eq("bp_latency_valid", 64'(data_valid_o), 64'd1);
    phy_fifo_full_i = 1'b1;
    drive_beat(32'h88776655, 4'hF, 1'b1, 4'h2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check_eq("bp_tready", 64'(s_axis_tready), 64'd0);
      check_eq("bp_wr_en", 64'(phy_fifo_wr_en_o), 64'd0);
      check_eq("bp_data_hold", 64'(data_o), 64'h332211FB);
      @(posedge clk_i);
      #1;
    end
    phy_fifo_full_i = 1'b0;
    wait_accept();
    wait_drain("bp_drain");

    // Dropped packets: Gen3 TLP, then tuser with no type bit
    curr_data_rate_i = RATE_GEN3;
    drop_packet("drop_gen3_tlp", 4'h2);
    gen3_dllp("after_drop_gen3_drain");
    curr_data_rate_i = RATE_GEN1;
    drop_packet("drop_tuser0", 4'h0);
    gen1_dllp("after_drop_tuser0_drain");

    // Asynchronous reset in the middle of a TLP
    send_beat(32'h44332211, 4'hF, 1'b0, 4'h2);
    drive_beat(32'h88776655, 4'hF, 1'b1, 4'h2);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(data_valid_o), 64'd0);
    check_eq("async_rst_wr_en", 64'(phy_fifo_wr_en_o), 64'd0);
    check_eq("async_rst_tready", 64'(s_axis_tready), 64'd0);
    check_eq("async_rst_word", 64'({sync_header_o, data_k_o, data_o}), 64'd0);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    gen1_dllp("after_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
